// File: rtl/pixel_lpf.sv
// Horizontal [1 2 1]/4 low-pass filter on the 18-bit capture stream, with an output
// FIFO drained one pixel at a time through the request_pixel / pixel_flag handshake.
module pixel_lpf #(
  parameter int LINE_WIDTH = 640,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_flag_in,
  input  logic [17:0] vid_pixel,
  input  logic        vid_valid,
  input  logic        request_pixel,
  output logic [17:0] pixel,
  output logic        pixel_flag,
  output logic        frame_flag,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(LINE_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, FIRST, RUN, FLUSH} state_t;

  // 8-bit sum peaks at 254, so the shifted result always fits in 6 bits
  function automatic logic [5:0] tap(input logic [5:0] a, input logic [5:0] b,
                                     input logic [5:0] c);
    logic [7:0] s;
    s = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + 8'd2;
    return s[7:2];
  endfunction

  function automatic logic [17:0] filt(input logic [17:0] a, input logic [17:0] b,
                                       input logic [17:0] c);
    return {tap(a[17:12], b[17:12], c[17:12]),
            tap(a[11:6],  b[11:6],  c[11:6]),
            tap(a[5:0],   b[5:0],   c[5:0])};
  endfunction

  state_t          state;
  logic [CW-1:0]   col;
  logic [17:0]     prev;
  logic [17:0]     cur;
  logic [17:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            wr_req;
  logic            wr_drop;
  logic            wr_en;
  logic            flush_drop;
  logic [17:0]     wr_data;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  // A frame start clears the FIFO, so it also suppresses the pop of that cycle
  assign pop        = !fifo_empty && request_pixel && !pixel_flag && !frame_flag_in;
  assign wr_req     = !frame_flag_in && ((state == RUN && vid_valid) || state == FLUSH);
  assign wr_data    = (state == FLUSH) ? filt(prev, cur, cur) : filt(prev, cur, vid_pixel);
  assign wr_drop    = wr_req && fifo_full && !pop;
  assign wr_en      = wr_req && !wr_drop;
  assign flush_drop = (state == FLUSH) && vid_valid;

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      prev       <= '0;
      cur        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pixel      <= '0;
      pixel_flag <= 1'b0;
      frame_flag <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_flag <= frame_flag_in;
      pixel_flag <= pop;
      if (pop) pixel <= mem[rd_ptr];

      if (frame_flag_in) begin
        state    <= FIRST;
        col      <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= flush_drop;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (flush_drop || wr_drop) overflow <= 1'b1;

        case (state)
          IDLE: ;
          FIRST: begin
            if (vid_valid) begin
              prev  <= vid_pixel;
              cur   <= vid_pixel;
              col   <= CW'(1);
              state <= RUN;
            end
          end
          RUN: begin
            if (vid_valid) begin
              prev <= cur;
              cur  <= vid_pixel;
              col  <= col + 1'b1;
              if (col == CW'(LINE_WIDTH - 1)) state <= FLUSH;
            end
          end
          FLUSH: begin
            col   <= '0;
            state <= FIRST;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_lpf.sv
// Directed bench for pixel_lpf: a wide-line instance (640/16) and a 4-pixel-line instance
// share the same stimulus; each check looks at the instance whose geometry it needs.
module tb_pixel_lpf;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_flag_in;
  logic [17:0] vid_pixel;
  logic        vid_valid;
  logic        request_pixel;

  logic [17:0] pixel_b, pixel_s;
  logic        pixel_flag_b, pixel_flag_s;
  logic        frame_flag_b, frame_flag_s;
  logic        overflow_b, overflow_s;

  pixel_lpf #(.LINE_WIDTH(640), .FIFO_DEPTH(16)) dut_big (
    .clk(clk), .reset(reset), .frame_flag_in(frame_flag_in), .vid_pixel(vid_pixel),
    .vid_valid(vid_valid), .request_pixel(request_pixel), .pixel(pixel_b),
    .pixel_flag(pixel_flag_b), .frame_flag(frame_flag_b), .overflow(overflow_b)
  );

  pixel_lpf #(.LINE_WIDTH(4), .FIFO_DEPTH(16)) dut_small (
    .clk(clk), .reset(reset), .frame_flag_in(frame_flag_in), .vid_pixel(vid_pixel),
    .vid_valid(vid_valid), .request_pixel(request_pixel), .pixel(pixel_s),
    .pixel_flag(pixel_flag_s), .frame_flag(frame_flag_s), .overflow(overflow_s)
  );

  typedef struct {
    logic [17:0] px;
    logic [17:0] exp;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [17:0] qb[$];
  logic [17:0] qs[$];
  int          sb[$];

  always #5 clk = ~clk;

  // Captured output pulses, sampled mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pixel_flag_b) begin
      qb.push_back(pixel_b);
      sb.push_back(cyc);
    end
    if (pixel_flag_s) qs.push_back(pixel_s);
  end

  function automatic logic [17:0] pk(input int c2, input int c1, input int c0);
    return {c2[5:0], c1[5:0], c0[5:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [17:0] px);
    vid_pixel = px;
    vid_valid = 1'b1;
    tick(1);
    vid_valid = 1'b0;
    tick(2);
  endtask

  task automatic framePulse();
    frame_flag_in = 1'b1;
    tick(1);
    frame_flag_in = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkPix(input string name, input bit big, input int idx, input logic [17:0] exp);
    if (big ? (idx < qb.size()) : (idx < qs.size()))
      checkOutput(name, 32'(big ? qb[idx] : qs[idx]), 32'(exp));
    else begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got no pixel, expected %0h", name, exp);
    end
  endtask

  vec_t vecs[8];
  int   base;
  int   min_gap;

  initial begin
    // Two 4-pixel lines for the small instance, expected values worked by hand
    vecs[0] = '{pk(0, 63, 0),  pk(16, 63, 1)};
    vecs[1] = '{pk(63, 63, 4), pk(32, 63, 4)};
    vecs[2] = '{pk(0, 63, 8),  pk(32, 63, 8)};
    vecs[3] = '{pk(63, 63, 12), pk(47, 63, 11)};
    vecs[4] = '{pk(63, 10, 1), pk(47, 8, 1)};
    vecs[5] = '{pk(0, 0, 2),   pk(16, 3, 2)};
    vecs[6] = '{pk(0, 0, 3),   pk(0, 3, 3)};
    vecs[7] = '{pk(0, 10, 5),  pk(0, 8, 5)};

    reset = 1'b1;
    frame_flag_in = 1'b0;
    vid_valid = 1'b0;
    vid_pixel = '0;
    request_pixel = 1'b0;
    tick(2);
    checkOutput("reset_pixel", 32'(pixel_b), 32'h0);
    checkOutput("reset_flag", 32'(pixel_flag_b), 32'h0);
    checkOutput("reset_frame", 32'(frame_flag_b), 32'h0);
    checkOutput("reset_ovf", 32'(overflow_b), 32'h0);
    reset = 1'b0;
    tick(1);

    $display("[TB] ramp / edge replication on 4-pixel lines");
    request_pixel = 1'b1;
    framePulse();
    base = qs.size();
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i].px);
    tick(10);
    checkOutput("ramp_count", qs.size() - base, 8);
    for (int i = 0; i < 8; i++) checkPix($sformatf("ramp_px%0d", i), 1'b0, base + i, vecs[i].exp);

    $display("[TB] constant 640-pixel line");
    framePulse();
    base = qb.size();
    for (int i = 0; i < 640; i++) applyStimulus(18'h3FFFF);
    tick(10);
    checkOutput("const_count", qb.size() - base, 640);
    for (int i = 0; i < 640; i++) checkPix($sformatf("const_px%0d", i), 1'b1, base + i, 18'h3FFFF);
    min_gap = 1000;
    for (int i = base + 1; i < qb.size(); i++)
      if (sb[i] - sb[i-1] < min_gap) min_gap = sb[i] - sb[i-1];
    checkOutput("const_gap_ge2", 32'(min_gap >= 2), 32'h1);
    checkOutput("const_ovf", 32'(overflow_b), 32'h0);

    $display("[TB] FIFO fill with request low");
    request_pixel = 1'b0;
    framePulse();
    base = qb.size();
    for (int i = 0; i < 20; i++) applyStimulus(pk(0, 0, 2 * i));
    checkOutput("fill_ovf", 32'(overflow_b), 32'h1);
    checkOutput("fill_no_pulse", qb.size() - base, 0);
    request_pixel = 1'b1;
    tick(60);
    checkOutput("fill_count", qb.size() - base, 16);
    for (int k = 0; k < 16; k++)
      checkPix($sformatf("fill_px%0d", k), 1'b1, base + k, pk(0, 0, (k == 0) ? 1 : 2 * k));

    $display("[TB] frame start mid-line");
    request_pixel = 1'b0;
    framePulse();
    for (int i = 0; i < 300; i++) applyStimulus(18'h3FFFF);
    framePulse();
    checkOutput("mid_frame_flag", 32'(frame_flag_b), 32'h1);
    checkOutput("mid_ovf_cleared", 32'(overflow_b), 32'h0);
    tick(1);
    checkOutput("mid_frame_flag_drop", 32'(frame_flag_b), 32'h0);
    base = qb.size();
    request_pixel = 1'b1;
    tick(10);
    checkOutput("mid_empty", qb.size() - base, 0);
    applyStimulus(pk(0, 0, 8));
    checkOutput("mid_first_px_no_out", qb.size() - base, 0);
    applyStimulus(pk(0, 0, 16));
    tick(4);
    checkOutput("mid_second_px_out", qb.size() - base, 1);
    checkPix("mid_value", 1'b1, base, pk(0, 0, 10));

    $display("[TB] vid_valid during the flush cycle");
    framePulse();
    base = qs.size();
    for (int i = 0; i < 3; i++) applyStimulus(pk(0, 0, 20));
    vid_pixel = pk(0, 0, 20);
    vid_valid = 1'b1;
    tick(1);
    vid_pixel = pk(0, 0, 63);
    tick(1);
    vid_valid = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) applyStimulus(pk(0, 0, 40));
    tick(10);
    checkOutput("flush_ovf", 32'(overflow_s), 32'h1);
    checkOutput("flush_count", qs.size() - base, 8);
    for (int i = 0; i < 8; i++)
      checkPix($sformatf("flush_px%0d", i), 1'b0, base + i, pk(0, 0, (i < 4) ? 20 : 40));

    $display("[TB] reset during a line");
    request_pixel = 1'b0;
    framePulse();
    for (int i = 0; i < 6; i++) applyStimulus(pk(0, 0, 30));
    reset = 1'b1;
    request_pixel = 1'b1;
    tick(1);
    checkOutput("rst_pixel", 32'(pixel_b), 32'h0);
    checkOutput("rst_flag", 32'(pixel_flag_b), 32'h0);
    checkOutput("rst_frame", 32'(frame_flag_b), 32'h0);
    checkOutput("rst_ovf", 32'(overflow_b), 32'h0);
    reset = 1'b0;
    base = qb.size();
    tick(6);
    checkOutput("rst_fifo_empty", qb.size() - base, 0);
    for (int i = 0; i < 3; i++) applyStimulus(pk(0, 0, 50));
    tick(4);
    checkOutput("rst_idle_ignores", qb.size() - base, 0);
    framePulse();
    applyStimulus(pk(0, 0, 8));
    applyStimulus(pk(0, 0, 16));
    tick(4);
    checkOutput("rst_recover_count", qb.size() - base, 1);
    checkPix("rst_recover_value", 1'b1, base, pk(0, 0, 10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
